// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snake_pkg
// Description : Shared direction encodings, scan codes and frame-state type
//               for the PS/2 arrow-key decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_P     = 8'h4D;

    function automatic logic is_arrow(input logic [7:0] code);
        return (code == SC_UP) || (code == SC_RIGHT) ||
               (code == SC_DOWN) || (code == SC_LEFT);
    endfunction

    function automatic dir_t arrow_dir(input logic [7:0] code);
        dir_t d;
        case (code)
            SC_UP:    d = DIR_UP;
            SC_RIGHT: d = DIR_RIGHT;
            SC_DOWN:  d = DIR_DOWN;
            default:  d = DIR_LEFT;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx_frame.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx_frame
// Description : PS/2 line synchroniser, clock glitch filter, 11-bit frame FSM
//               and mid-frame timeout. Macro PS2_PARITY_CHECK_EN enables the
//               odd-parity check.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx_frame
    import snake_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]            r_clk_sync;
    logic [1:0]            r_data_sync;
    logic [FILTER_LEN-1:0] r_hist;
    logic                  r_clk_filt;
    frame_state_t          r_state;
    frame_state_t          w_state_next;
    logic [2:0]            r_bit_cnt;
    logic [7:0]            r_shift;
    logic                  r_parity;
    logic [TW-1:0]         r_idle_cnt;
    logic                  r_byte_valid;
    logic                  r_frame_err;
    logic                  w_sample;
    logic                  w_fall;
    logic                  w_timeout;
    logic                  w_parity_ok;
    logic                  w_done;
    logic                  w_err;

    assign w_sample  = r_data_sync[1];
    assign w_fall    = r_clk_filt && (r_hist == '0);
    assign w_timeout = (r_state != ST_IDLE) && !w_fall &&
                       (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1));

`ifdef PS2_PARITY_CHECK_EN
    assign w_parity_ok = ^{r_shift, r_parity};
`else
    assign w_parity_ok = 1'b1;
`endif

    // Idle lines are high, so history resets to all ones to avoid a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_hist      <= '1;
            r_clk_filt  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
            r_hist      <= {r_hist[FILTER_LEN-2:0], r_clk_sync[1]};
            if (r_hist == '0) begin
                r_clk_filt <= 1'b0;
            end else if (&r_hist) begin
                r_clk_filt <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_timeout) begin
            w_state_next = ST_IDLE;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE:   if (!w_sample) w_state_next = ST_DATA;
                ST_DATA:   if (r_bit_cnt == 3'd7) w_state_next = ST_PARITY;
                ST_PARITY: w_state_next = ST_STOP;
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_done = 1'b0;
        w_err  = w_timeout;
        if (w_fall && (r_state == ST_STOP)) begin
            w_done = w_sample && w_parity_ok;
            w_err  = !(w_sample && w_parity_ok);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'd0;
            r_parity     <= 1'b0;
            r_idle_cnt   <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= w_done;
            r_frame_err  <= w_err;
            if ((r_state == ST_IDLE) || w_fall) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
            if (w_fall) begin
                case (r_state)
                    ST_IDLE: r_bit_cnt <= 3'd0;
                    ST_DATA: begin
                        r_shift   <= {w_sample, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    ST_PARITY: r_parity <= w_sample;
                    default: ;
                endcase
            end
        end
    end

    assign data_byte  = r_shift;
    assign byte_valid = r_byte_valid;
    assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: rtl/ps2_direction_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_direction_decoder
// Description : Decodes PS/2 scan codes into arrow direction and game control
//               levels. Macro PS2_PARITY_CHECK_EN enables parity rejection.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_direction_decoder
    import snake_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [1:0] direction,
    output logic       Keypressed,
    output logic       start,
    output logic       pause,
    output logic       esc,
    output logic       frame_err
);

    logic [7:0] w_byte;
    logic       w_byte_valid;
    logic       r_ext;
    logic       r_brk;
    dir_t       r_dir;
    logic       r_key;
    logic       r_start;
    logic       r_pause;
    logic       r_esc;

    ps2_rx_frame #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .data_byte  (w_byte),
        .byte_valid (w_byte_valid),
        .frame_err  (frame_err)
    );

    // Prefix bytes only set flags; any other byte consumes and clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ext   <= 1'b0;
            r_brk   <= 1'b0;
            r_dir   <= DIR_RIGHT;
            r_key   <= 1'b0;
            r_start <= 1'b0;
            r_pause <= 1'b0;
            r_esc   <= 1'b0;
        end else if (w_byte_valid) begin
            if (w_byte == SC_EXT) begin
                r_ext <= 1'b1;
            end else if (w_byte == SC_BREAK) begin
                r_brk <= 1'b1;
            end else begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
                if (r_ext) begin
                    if (is_arrow(w_byte)) begin
                        if (!r_brk) begin
                            r_dir <= arrow_dir(w_byte);
                            r_key <= 1'b1;
                        end else if (arrow_dir(w_byte) == r_dir) begin
                            r_key <= 1'b0;
                        end
                    end
                end else if (!r_brk) begin
                    case (w_byte)
                        SC_ENTER: r_start <= 1'b1;
                        SC_ESC: begin
                            r_start <= 1'b0;
                            r_pause <= 1'b0;
                            r_esc   <= 1'b1;
                        end
                        SC_P: if (r_start) r_pause <= ~r_pause;
                        default: ;
                    endcase
                end else if (w_byte == SC_ESC) begin
                    r_esc <= 1'b0;
                end
            end
        end
    end

    assign direction  = r_dir;
    assign Keypressed = r_key;
    assign start      = r_start;
    assign pause      = r_pause;
    assign esc        = r_esc;

endmodule
`default_nettype wire

// File: tb/tb_ps2_direction_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_direction_decoder
// Description : Self-checking bench driving PS/2 frames against a scan-code
//               behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_direction_decoder;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 50000;
    localparam int HALF           = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [1:0] direction;
    logic       Keypressed;
    logic       start;
    logic       pause;
    logic       esc;
    logic       frame_err;

    int checks = 0;
    int passed = 0;
    int err_cnt = 0;

    logic [1:0] m_dir;
    logic       m_key, m_start, m_pause, m_esc, m_ext, m_brk;

    ps2_direction_decoder #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .direction  (direction),
        .Keypressed (Keypressed),
        .start      (start),
        .pause      (pause),
        .esc        (esc),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
    end

    function automatic logic [5:0] obs();
        return {direction, Keypressed, start, pause, esc};
    endfunction

    function automatic logic [5:0] expv();
        return {m_dir, m_key, m_start, m_pause, m_esc};
    endfunction

    function automatic int arrow_index(input logic [7:0] b);
        logic [7:0] codes [4];
        codes = '{8'h75, 8'h74, 8'h72, 8'h6B};
        for (int i = 0; i < 4; i++) if (codes[i] == b) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_dir = 2'b01; m_key = 0; m_start = 0; m_pause = 0; m_esc = 0;
        m_ext = 0; m_brk = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int a;
        a = arrow_index(b);
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            if (m_ext) begin
                if (a >= 0 && !m_brk) begin m_dir = a[1:0]; m_key = 1; end
                else if (a >= 0 && a[1:0] == m_dir) m_key = 0;
            end else if (!m_brk) begin
                if (b == 8'h5A) m_start = 1;
                else if (b == 8'h76) begin m_start = 0; m_pause = 0; m_esc = 1; end
                else if (b == 8'h4D && m_start) m_pause = !m_pause;
            end else if (b == 8'h76) m_esc = 0;
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic half();
        repeat (HALF) @(negedge clk);
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad);
        return {1'b1, (~^b) ^ bad, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            half();
            ps2_clk = 1'b0;
            half();
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(make_frame(b, 1'b0), 11);
        half();
        model_byte(b);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        if ({obs(), frame_err} !== 7'b01_0000_0) begin
            $display("FAIL reset_values: got %b want %b", {obs(), frame_err}, 7'b01_0000_0);
        end else passed++;
        checks++;
        rst = 1'b0;
        half();
    endtask

    task automatic test_arrow_latency();
        logic [10:0] f;
        send_byte(8'hE0);
        f = make_frame(8'h75, 1'b0);
        send_bits(f, 10);
        ps2_data = 1'b1;
        half();
        ps2_clk = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        if (obs() !== expv()) begin
            $display("FAIL arrow_early: got %b want %b", obs(), expv());
        end else passed++;
        checks++;
        model_byte(8'h75);
        @(posedge clk);
        #1;
        if (obs() !== expv()) begin
            $display("FAIL arrow_latency: got %b want %b", obs(), expv());
        end else passed++;
        checks++;
        @(negedge clk);
        half();
        ps2_clk = 1'b1;
        half();
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        if ({direction, Keypressed} !== 3'b00_0 || obs() !== expv()) begin
            $display("FAIL arrow_release: got %b want %b", obs(), expv());
        end else passed++;
        checks++;
    endtask

    task automatic test_arrow_switch();
        logic [7:0] seq [8];
        seq = '{8'hE0, 8'h6B, 8'hE0, 8'h74, 8'hE0, 8'hF0, 8'h6B, 8'hE0};
        for (int i = 0; i < 7; i++) begin
            send_byte(seq[i]);
            if (obs() !== expv()) begin
                $display("FAIL arrow_switch[%0d]: got %b want %b", i, obs(), expv());
            end else passed++;
            checks++;
        end
        if ({direction, Keypressed} !== 3'b01_1) begin
            $display("FAIL arrow_switch_final: got %b want %b", {direction, Keypressed}, 3'b01_1);
        end else passed++;
        checks++;
    endtask

    task automatic test_game_keys();
        logic [7:0] seq [6];
        seq = '{8'h5A, 8'h4D, 8'h4D, 8'h76, 8'hF0, 8'h76};
        for (int i = 0; i < 6; i++) begin
            send_byte(seq[i]);
            if (obs() !== expv()) begin
                $display("FAIL game_keys[%0d]: got %b want %b", i, obs(), expv());
            end else passed++;
            checks++;
        end
        if ({start, pause, esc} !== 3'b000) begin
            $display("FAIL game_keys_final: got %b want %b", {start, pause, esc}, 3'b000);
        end else passed++;
        checks++;
    endtask

    task automatic test_parity();
        int e0;
        int want_err;
        e0 = err_cnt;
        send_bits(make_frame(8'h5A, 1'b1), 11);
        half();
`ifdef PS2_PARITY_CHECK_EN
        want_err = 1;
`else
        want_err = 0;
        model_byte(8'h5A);
`endif
        if (err_cnt - e0 !== want_err) begin
            $display("FAIL parity_err: got %0d want %0d", err_cnt - e0, want_err);
        end else passed++;
        checks++;
        if (obs() !== expv()) begin
            $display("FAIL parity_outputs: got %b want %b", obs(), expv());
        end else passed++;
        checks++;
    endtask

    task automatic test_timeout();
        int e0;
        int waited;
        send_byte(8'h76);
        send_byte(8'hF0);
        send_byte(8'h76);
        e0 = err_cnt;
        send_bits(make_frame(8'h5A, 1'b0), 4);
        waited = 0;
        while (err_cnt == e0 && waited < TIMEOUT_CYCLES + 200) begin
            @(negedge clk);
            waited++;
        end
        repeat (20) @(negedge clk);
        if (err_cnt - e0 !== 1 || waited < TIMEOUT_CYCLES - 20 || waited > TIMEOUT_CYCLES + 20) begin
            $display("FAIL timeout_err: pulses %0d after %0d cycles, want 1 near %0d",
                     err_cnt - e0, waited, TIMEOUT_CYCLES);
        end else passed++;
        checks++;
        if (obs() !== expv()) begin
            $display("FAIL timeout_outputs: got %b want %b", obs(), expv());
        end else passed++;
        checks++;
        send_byte(8'h5A);
        if (start !== 1'b1 || obs() !== expv()) begin
            $display("FAIL timeout_recover: got %b want %b", obs(), expv());
        end else passed++;
        checks++;
    endtask

    task automatic test_reset_midframe();
        int e0;
        e0 = err_cnt;
        send_bits(make_frame(8'hE0, 1'b0), 5);
        ps2_clk = 1'b0;
        ps2_data = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        if (obs() !== 6'b01_0000 || frame_err !== 1'b0) begin
            $display("FAIL midframe_reset: got %b want %b", obs(), 6'b01_0000);
        end else passed++;
        checks++;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        half();
        if (err_cnt !== e0) begin
            $display("FAIL midframe_noerr: got %0d pulses want 0", err_cnt - e0);
        end else passed++;
        checks++;
        send_byte(8'hE0);
        send_byte(8'h72);
        if ({direction, Keypressed} !== 3'b10_1 || obs() !== expv()) begin
            $display("FAIL midframe_next: got %b want %b", obs(), expv());
        end else passed++;
        checks++;
    endtask

    task automatic test_random();
        logic [7:0] pool [9];
        logic [7:0] b;
        int e0;
        pool = '{8'hE0, 8'hF0, 8'h75, 8'h74, 8'h72, 8'h6B, 8'h5A, 8'h76, 8'h4D};
        e0 = err_cnt;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 7) == 0) b = 8'($urandom);
            else b = pool[$urandom_range(0, 8)];
            send_byte(b);
            if (obs() !== expv()) begin
                $display("FAIL random[%0d] byte %h: got %b want %b", i, b, obs(), expv());
            end else passed++;
            checks++;
        end
        if (err_cnt !== e0) begin
            $display("FAIL random_noerr: got %0d pulses want 0", err_cnt - e0);
        end else passed++;
        checks++;
    endtask

    initial begin
        test_reset();
        test_arrow_latency();
        test_arrow_switch();
        test_game_keys();
        test_parity();
        test_timeout();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
